// File: rtl/button_capture_ctrl_pkg.sv
// Shared definitions for the switch-capture path: FSM state encodings and default sizing.
package button_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS_DB = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_HOLD     = 3'd3,
        ST_REL_DB   = 3'd4
    } state_t;

    localparam int DEF_DATA_W   = 13;
    localparam int DEF_DEBOUNCE = 20000;
    localparam int DEF_CNT_W    = 15;

endpackage

// File: rtl/button_capture_ctrl_sync_2ff.sv
// Two-flop synchroniser with async reset, used for every asynchronous dev-board input.
module button_capture_ctrl_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/button_capture_ctrl.sv
// Debounces the push-button and takes one snapshot of the switch bus per press,
// handing it to the CPU through a valid/ack handshake with a sticky overrun flag.
module button_capture_ctrl
    import button_capture_ctrl_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              ack,
    input  logic              clr_overrun,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              capture_pulse,
    output logic              overrun,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic              w_btn_s;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_capture_pulse;
    logic              r_overrun;
    logic              r_busy;

    button_capture_ctrl_sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (button),
        .o_q (w_btn_s)
    );

    // Handshake updates come first so that a capture on the same edge overrides
    // an ack, and a new overrun overrides a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_out_data      <= '0;
            r_out_valid     <= 1'b0;
            r_capture_pulse <= 1'b0;
            r_overrun       <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_capture_pulse <= 1'b0;
            if (ack && r_out_valid) begin
                r_out_valid <= 1'b0;
            end
            if (clr_overrun) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_btn_s) begin
                        r_state <= ST_PRESS_DB;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PRESS_DB: begin
                    if (!w_btn_s) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state         <= ST_CAPTURE;
                        r_cnt           <= '0;
                        r_capture_pulse <= 1'b1;
                        r_out_data      <= sw_data;
                        r_out_valid     <= 1'b1;
                        if (r_out_valid && !ack) begin
                            r_overrun <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_HOLD;
                    r_cnt   <= '0;
                end
                ST_HOLD: begin
                    if (!w_btn_s) begin
                        r_state <= ST_REL_DB;
                        r_cnt   <= '0;
                    end
                end
                ST_REL_DB: begin
                    if (w_btn_s) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data      = r_out_data;
    assign out_valid     = r_out_valid;
    assign capture_pulse = r_capture_pulse;
    assign overrun       = r_overrun;
    assign busy          = r_busy;

endmodule

// File: tb/tb_button_capture_ctrl.sv
// Self-checking bench for button_capture_ctrl with a short debounce window (DEBOUNCE=4).
module tb_button_capture_ctrl;

    typedef struct {
        logic        button;
        logic [12:0] sw;
        logic        ack;
        logic        clr;
        logic [12:0] expData;
        logic        expValid;
        logic        expPulse;
        logic        expOvr;
        logic        expBusy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        button = 1'b0;
    logic [12:0] sw_data = '0;
    logic        ack = 1'b0;
    logic        clr_overrun = 1'b0;
    logic [12:0] out_data;
    logic        out_valid;
    logic        capture_pulse;
    logic        overrun;
    logic        busy;

    int nChecks = 0;
    int nPass   = 0;
    vec_t vecs[$];

    button_capture_ctrl #(
        .DATA_W   (13),
        .DEBOUNCE (4),
        .CNT_W    (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button        (button),
        .sw_data       (sw_data),
        .ack           (ack),
        .clr_overrun   (clr_overrun),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .capture_pulse (capture_pulse),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and return 1ns after the edge that samples them.
    task automatic applyStimulus(input logic b, input logic [12:0] s, input logic a, input logic c);
        button      = b;
        sw_data     = s;
        ack         = a;
        clr_overrun = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [12:0] eData, input logic eValid,
                               input logic ePulse, input logic eOvr, input logic eBusy);
        nChecks++;
        if ({out_data, out_valid, capture_pulse, overrun, busy} === {eData, eValid, ePulse, eOvr, eBusy}) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got data=%h valid=%b pulse=%b ovr=%b busy=%b, expected data=%h valid=%b pulse=%b ovr=%b busy=%b",
                     name, out_data, out_valid, capture_pulse, overrun, busy, eData, eValid, ePulse, eOvr, eBusy);
        end
    endtask

    task automatic checkInt(input string name, input int actual, input int expected);
        nChecks++;
        if (actual == expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Full press from IDLE: 10 cycles held, 10 released; capture due on cycle 6.
    task automatic pressCycle(input string name, input logic [12:0] s, input logic ackCap, input logic clrCap);
        int pulses;
        int firstAt;
        pulses  = 0;
        firstAt = -1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(i < 10, s, ackCap && (i == 6), clrCap && (i == 6));
            if (capture_pulse) begin
                pulses++;
                if (firstAt < 0) firstAt = i;
            end
        end
        applyStimulus(1'b0, s, 1'b0, 1'b0);
        checkInt({name, "_pulse_count"}, pulses, 1);
        checkInt({name, "_pulse_edge"}, firstAt, 6);
        checkInt({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int pulses;
        int firstAt;
        int busyDrops;

        // Clean press, release and ack, one vector per clock edge.
        vecs.push_back('{1'b1, 13'h1ABC, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 13'h1ABC, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 13'h1ABC, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 13'h1ABC, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 13'h1ABC, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 13'h1ABC, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 13'h1ABC, 1'b0, 1'b0, 13'h1ABC, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 13'h1ABC, 1'b0, 1'b0, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 13'h0F0F, 1'b0, 1'b0, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 13'h0F0F, 1'b0, 1'b0, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 13'h0F0F, 1'b0, 1'b0, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 13'h0F0F, 1'b0, 1'b0, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 13'h0F0F, 1'b0, 1'b0, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 13'h0F0F, 1'b0, 1'b0, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 13'h0F0F, 1'b0, 1'b0, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 13'h0F0F, 1'b1, 1'b0, 13'h1ABC, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 13'h0F0F, 1'b1, 1'b0, 13'h1ABC, 1'b0, 1'b0, 1'b0, 1'b0});

        #12;
        checkOutput("reset_state", 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] clean press table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].button, vecs[i].sw, vecs[i].ack, vecs[i].clr);
            checkOutput($sformatf("table_%0d", i), vecs[i].expData, vecs[i].expValid,
                        vecs[i].expPulse, vecs[i].expOvr, vecs[i].expBusy);
        end

        $display("[TB] bounce");
        pulses  = 0;
        firstAt = -1;
        for (int i = 0; i < 30; i++) begin
            applyStimulus((i != 2) && (i < 20), 13'h0AAA, 1'b0, 1'b0);
            if (capture_pulse) begin
                pulses++;
                if (firstAt < 0) firstAt = i;
            end
        end
        checkInt("bounce_pulse_count", pulses, 1);
        checkInt("bounce_pulse_edge", firstAt, 9);
        checkOutput("bounce_result", 13'h0AAA, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0);
        checkOutput("bounce_ack", 13'h0AAA, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] hold with release glitch");
        pulses    = 0;
        firstAt   = -1;
        busyDrops = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus((i < 50) && (i != 30) && (i != 31), 13'h0555, 1'b0, 1'b0);
            if (capture_pulse) begin
                pulses++;
                if (firstAt < 0) firstAt = i;
            end
            if (i >= 2 && i <= 55 && !busy) busyDrops++;
            if (i == 56) checkInt("glitch_release_idle", int'(busy), 0);
        end
        checkInt("glitch_pulse_count", pulses, 1);
        checkInt("glitch_pulse_edge", firstAt, 6);
        checkInt("glitch_busy_drops", busyDrops, 0);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0);
        checkOutput("glitch_ack", 13'h0555, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] overrun");
        pressCycle("ovr_first", 13'h0001, 1'b0, 1'b0);
        checkOutput("ovr_first_data", 13'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        pressCycle("ovr_second", 13'h0002, 1'b0, 1'b0);
        checkOutput("ovr_set", 13'h0002, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 13'h0000, 1'b0, 1'b1);
        checkOutput("ovr_clear", 13'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        pressCycle("ovr_set_vs_clr", 13'h0003, 1'b0, 1'b1);
        checkOutput("ovr_set_wins", 13'h0003, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 13'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0);
        checkOutput("ovr_ack", 13'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0);
        checkOutput("ack_when_empty", 13'h0003, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] same-edge ack");
        pressCycle("same_pre", 13'h0100, 1'b0, 1'b0);
        pressCycle("same_edge", 13'h0200, 1'b1, 1'b0);
        checkOutput("same_edge_result", 13'h0200, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset mid-press");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 13'h0777, 1'b0, 1'b0);
        checkOutput("press_before_reset", 13'h0200, 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("reset_mid_press", 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 13'h0777, 1'b0, 1'b0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 13'h0777, 1'b0, 1'b0);
            if (capture_pulse) pulses++;
        end
        checkInt("after_reset_press_pulses", pulses, 0);
        checkOutput("after_reset_press", 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset mid-hold");
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 13'h0999, 1'b0, 1'b0);
        checkOutput("hold_before_reset", 13'h0999, 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("reset_mid_hold", 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 13'h0999, 1'b0, 1'b0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 13'h0999, 1'b0, 1'b0);
            if (capture_pulse) pulses++;
        end
        checkInt("after_reset_hold_pulses", pulses, 0);
        pressCycle("fresh_press", 13'h1FFF, 1'b0, 1'b0);
        checkOutput("fresh_press_data", 13'h1FFF, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
